// File: rtl/lu_run_controller.sv
// Run sequencer for the 3-variable LU solver: start handshake, timeout
// supervision, fault latching and result display cycling.
module lu_run_controller #(
    parameter int DWELL_CYCLES   = 50000000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic       LU_done,
    input  logic       LU_error_ovf,
    input  logic       LU_error_dbz,
    input  logic       LU_error_FSM,
    output logic       LU_en,
    output logic [1:0] disp_control,
    output logic       busy,
    output logic       result_valid,
    output logic [2:0] err_code,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHOW  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       DISP_BLANK = 2'b11;

    state_t           state;
    logic             start_q;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic             start_edge;
    logic [2:0]       errs;

    assign start_edge = start & ~start_q;
    assign errs       = {LU_error_FSM, LU_error_dbz, LU_error_ovf};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            dwell_cnt    <= '0;
            run_cnt      <= '0;
            LU_en        <= 1'b0;
            disp_control <= DISP_BLANK;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            err_code     <= 3'b000;
            timeout      <= 1'b0;
        end else begin
            start_q <= start;
            // Any non-RUN state restarts identically on a start edge.
            if (start_edge && (state == IDLE || state == SHOW ||
                               state == FAULT)) begin
                state        <= RUN;
                LU_en        <= 1'b1;
                busy         <= 1'b1;
                result_valid <= 1'b0;
                disp_control <= DISP_BLANK;
                err_code     <= 3'b000;
                timeout      <= 1'b0;
                run_cnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    RUN: begin
                        if (LU_done) begin
                            LU_en <= 1'b0;
                            busy  <= 1'b0;
                            if (|errs) begin
                                err_code     <= errs;
                                state        <= FAULT;
                                disp_control <= DISP_BLANK;
                            end else begin
                                state        <= SHOW;
                                disp_control <= 2'b00;
                                result_valid <= 1'b1;
                                dwell_cnt    <= '0;
                            end
                        end else if (run_cnt == TO_LAST) begin
                            state   <= FAULT;
                            timeout <= 1'b1;
                            LU_en   <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (!hold) begin
                            if (dwell_cnt == DWELL_LAST) begin
                                dwell_cnt    <= '0;
                                disp_control <= (disp_control == 2'b10) ?
                                                2'b00 : disp_control + 2'b01;
                            end else begin
                                dwell_cnt <= dwell_cnt + 1'b1;
                            end
                        end
                    end
                    FAULT: begin
                        LU_en        <= 1'b0;
                        disp_control <= DISP_BLANK;
                    end
                    default: begin
                        state        <= IDLE;
                        dwell_cnt    <= '0;
                        run_cnt      <= '0;
                        LU_en        <= 1'b0;
                        disp_control <= DISP_BLANK;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                        err_code     <= 3'b000;
                        timeout      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lu_run_controller.sv
// Directed vector bench for lu_run_controller with a short dwell and timeout.
module tb_lu_run_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hold;
    logic       LU_done;
    logic       LU_error_ovf;
    logic       LU_error_dbz;
    logic       LU_error_FSM;
    logic       LU_en;
    logic [1:0] disp_control;
    logic       busy;
    logic       result_valid;
    logic [2:0] err_code;
    logic       timeout;

    lu_run_controller #(
        .DWELL_CYCLES   (4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hold         (hold),
        .LU_done      (LU_done),
        .LU_error_ovf (LU_error_ovf),
        .LU_error_dbz (LU_error_dbz),
        .LU_error_FSM (LU_error_FSM),
        .LU_en        (LU_en),
        .disp_control (disp_control),
        .busy         (busy),
        .result_valid (result_valid),
        .err_code     (err_code),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Output vector: {LU_en, disp[1:0], busy, result_valid, err[2:0], timeout}
    typedef struct {
        logic       s;
        logic       h;
        logic       d;
        logic [2:0] e;
        logic [8:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [8:0] IDLE_O = {1'b0, 2'b11, 1'b0, 1'b0, 3'b000, 1'b0};
    localparam logic [8:0] RUN_O  = {1'b1, 2'b11, 1'b1, 1'b0, 3'b000, 1'b0};

    function automatic logic [8:0] show_o(input logic [1:0] d);
        return {1'b0, d, 1'b0, 1'b1, 3'b000, 1'b0};
    endfunction

    function automatic logic [8:0] fault_o(input logic [2:0] e,
                                           input logic t);
        return {1'b0, 2'b11, 1'b0, 1'b0, e, t};
    endfunction

    function automatic void add(input int n, input logic s, input logic h,
                                input logic d, input logic [2:0] e,
                                input logic [8:0] exp, input string tag);
        vec_t v;
        v.s = s; v.h = h; v.d = d; v.e = e; v.exp = exp; v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic logic [8:0] outs();
        return {LU_en, disp_control, busy, result_valid, err_code, timeout};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = outs();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (#%0d): got %b expected %b",
                     tag, n_vec, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic h, input logic d,
                        input logic [2:0] e, input logic [8:0] exp,
                        input string tag);
        start        = s;
        hold         = h;
        LU_done      = d;
        LU_error_FSM = e[2];
        LU_error_dbz = e[1];
        LU_error_ovf = e[0];
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check(tag, IDLE_O);
        @(posedge clk);
        #1;
        check({tag, "_held"}, IDLE_O);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; hold = 1'b0; LU_done = 1'b0;
        LU_error_ovf = 1'b0; LU_error_dbz = 1'b0; LU_error_FSM = 1'b0;

        add(2,  0, 0, 0, 3'b000, IDLE_O,      "idle");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "start_edge");
        add(6,  1, 0, 0, 3'b000, RUN_O,       "start_held");
        add(1,  1, 0, 1, 3'b000, show_o(0),   "done_ok");
        add(2,  1, 0, 0, 3'b000, show_o(0),   "no_reedge");
        add(1,  0, 0, 0, 3'b000, show_o(0),   "dwell_pre");
        add(1,  0, 0, 0, 3'b000, show_o(1),   "dwell_x1");
        add(3,  0, 0, 0, 3'b000, show_o(1),   "dwell_x1_hold");
        add(1,  0, 0, 0, 3'b000, show_o(2),   "dwell_x2");
        add(3,  0, 0, 0, 3'b000, show_o(2),   "dwell_x2_hold");
        add(1,  0, 0, 0, 3'b000, show_o(0),   "dwell_wrap");
        add(6,  0, 1, 0, 3'b000, show_o(0),   "hold_freeze");
        add(3,  0, 0, 0, 3'b000, show_o(0),   "hold_release");
        add(1,  0, 0, 0, 3'b000, show_o(1),   "hold_advance");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "show_restart");
        add(1,  0, 0, 0, 3'b000, RUN_O,       "run");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "run_edge_ignored");
        add(1,  0, 0, 1, 3'b011, fault_o(3'b011, 0), "err_dbz_ovf");
        add(2,  0, 0, 0, 3'b000, fault_o(3'b011, 0), "fault_hold");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "fault_restart");
        add(15, 0, 0, 0, 3'b000, RUN_O,       "run_wait");
        add(1,  0, 0, 0, 3'b000, fault_o(3'b000, 1), "timeout");
        add(2,  0, 0, 0, 3'b000, fault_o(3'b000, 1), "timeout_hold");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "timeout_restart");
        add(1,  0, 0, 1, 3'b100, fault_o(3'b100, 0), "err_fsm");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "fsm_restart");
        add(15, 0, 0, 0, 3'b000, RUN_O,       "run_wait2");
        add(1,  0, 0, 1, 3'b000, show_o(0),   "done_at_limit");
        add(3,  0, 0, 0, 3'b000, show_o(0),   "dwell_pre2");
        add(1,  1, 0, 0, 3'b000, RUN_O,       "edge_vs_dwell");
        add(2,  1, 0, 0, 3'b000, RUN_O,       "rerun");
        add(1,  1, 0, 1, 3'b000, show_o(0),   "second_done");
        add(3,  0, 0, 0, 3'b000, show_o(0),   "dwell_pre3");
        add(1,  0, 0, 0, 3'b000, show_o(1),   "dwell_x1_again");

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", IDLE_O);
        rst = 1'b1;

        foreach (vecs[i])
            step(vecs[i].s, vecs[i].h, vecs[i].d, vecs[i].e,
                 vecs[i].exp, vecs[i].tag);

        async_reset("rst_show");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 3'b000, IDLE_O, "idle_after_rst_show");
        step(1, 0, 0, 3'b000, RUN_O, "run_for_rst");
        step(1, 0, 0, 3'b000, RUN_O, "run_for_rst2");
        start = 1'b0;
        async_reset("rst_run");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 3'b000, IDLE_O, "idle_after_rst_run");
        step(1, 0, 0, 3'b000, RUN_O, "restart_after_rst");
        step(1, 0, 1, 3'b000, show_o(0), "done_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lu_run_controller.md
Name: lu_run_controller

Overview:
- Sequences one run of main_3_vari_equation_solver: converts a start request into the LU_en handshake and supervises completion with a timeout.
- On clean completion, auto-cycles the display select through X0, X1, X2; on error or timeout, latches the cause and blanks the display.
- Sits between the board inputs and the solver.

Parameters:
- DWELL_CYCLES, 50000000, clocks each result stays displayed before advancing (minimum 2).
- TIMEOUT_CYCLES, 1000000, clocks in RUN without LU_done before a timeout fault (minimum 2).
- CNT_W, 32, width of the dwell and timeout counters; must hold both parameter values.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  debounced, clk-synchronous run request; level input, rising edge acts
- hold  input  1  freezes display cycling while high
- LU_done  input  1  solver done
- LU_error_ovf  input  1  solver overflow flag
- LU_error_dbz  input  1  solver divide-by-zero flag
- LU_error_FSM  input  1  solver illegal-state flag
- LU_en  output  1  solver enable, to the solver's LU_en
- disp_control  output  2  solver display select: 00 X0, 01 X1, 10 X2, 11 blank/FFFF
- busy  output  1  high while in RUN
- result_valid  output  1  high while in SHOW
- err_code  output  3  latched {FSM, dbz, ovf}
- timeout  output  1  latched timeout fault

Behaviour:
- All state is registered; outputs are driven directly from registers.
- Reset (rst low, asynchronous) forces:
  - state IDLE, LU_en 0, disp_control 11, busy 0, result_valid 0, err_code 000, timeout 0;
  - counters cleared and start_q cleared.
- Reset mid-run aborts immediately. After release the block waits for a new start edge.
- Start edge: start_q registers start every clock. An edge is start=1 while start_q=0. Holding start high produces exactly one edge.
- States: IDLE, RUN, SHOW, FAULT.
- IDLE:
  - On an edge at clock k, after clock k: state RUN, LU_en 1, busy 1, disp_control 11, err_code 000, timeout 0, timeout counter 0.
  - Otherwise hold.
- RUN:
  - LU_en held 1. Start edges are ignored. The timeout counter increments every clock.
  - If LU_done=1 at clock k, after clock k: LU_en 0, busy 0, then:
    - any error flag = 1: err_code <= {FSM, dbz, ovf}, state FAULT, disp_control 11;
    - no error flags: state SHOW, disp_control 00, result_valid 1, dwell counter 0.
  - Else if the counter equals TIMEOUT_CYCLES-1: state FAULT, timeout 1, LU_en 0, busy 0, err_code unchanged (000).
  - If LU_done and the timeout compare coincide, LU_done wins.
- SHOW:
  - Dwell counter increments each clock while hold=0; frozen while hold=1.
  - When the counter equals DWELL_CYCLES-1 with hold=0: counter goes to 0 and disp_control advances 00->01->10->00 (wraps; 11 is never produced in SHOW).
  - A start edge takes priority over the dwell advance: enter RUN exactly as from IDLE, with result_valid 0 and disp_control 11.
- FAULT:
  - LU_en 0, disp_control 11; err_code and timeout hold.
  - A start edge enters RUN as from IDLE, clearing err_code and timeout.
- LU_en is low for at least one clock between consecutive runs, because SHOW/FAULT always separate two RUNs. The solver relies on this to re-arm.
- Counter arithmetic is unsigned CNT_W with no wrap-around inside a run: the compare terminates each count before overflow.
- Illegal state encoding recovers to IDLE with the reset output values.

Test Plan (DWELL_CYCLES=4, TIMEOUT_CYCLES=16):
- Reset, then start high at clock 3 -> LU_en=1 and busy=1 after clock 3. Hold start high 10 clocks -> only one run; no extra edges.
- Model LU_done=1, no errors, 7 clocks after LU_en -> LU_en=0, result_valid=1, disp_control=00. disp_control then reads 01, 10, 00 after 4, 8, 12 further clocks. hold=1 for 6 clocks freezes the value and counter.
- LU_done=1 with dbz=1 and ovf=1 -> state FAULT, err_code=011, disp_control=11, LU_en=0. New start edge -> err_code=000, LU_en=1.
- LU_done never asserted -> timeout=1 and LU_en=0 exactly 16 clocks after LU_en rose. LU_done on the 16th clock instead -> SHOW, timeout=0.
- rst low mid-RUN and mid-SHOW -> outputs immediately return to reset values asynchronously. No run resumes until a new start edge.
- Start edge in SHOW coinciding with the dwell advance -> RUN entered, disp_control=11, result_valid=0. A second LU_done completes normally.
